// File: rtl/boxhead_pkg.sv
// Shared types and screen constants for the Boxhead player/sprite path.
package boxhead_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef logic [1:0] step_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/player_sprite_fetch.sv
// Player sprite fetch: snapshots player state once per frame and turns the
// beam position into a sprite-sheet ROM address {dir, step, dy, dx} plus a
// hit flag delayed one more cycle so it lines up with the ROM read data.
module player_sprite_fetch
    import boxhead_pkg::*;
#(
    parameter  int SPR_LOG2 = 5,
    localparam int ADDR_W   = 4 + 2*SPR_LOG2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Frame_Tick,
    input  logic [9:0]        Player_X,
    input  logic [9:0]        Player_Y,
    input  logic [1:0]        Player_Dir,
    input  logic              Player_Moving,
    input  logic [1:0]        Obj_Step_Count,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              Blank_n,
    output logic [ADDR_W-1:0] Sprite_Addr,
    output logic              Sprite_Hit
);

    // Per-frame snapshot of player state
    logic [9:0] snap_x_q, snap_x_d;
    logic [9:0] snap_y_q, snap_y_d;
    dir_t       snap_dir_q, snap_dir_d;
    step_t      snap_step_q, snap_step_d;

    // Stage 1: box test and sprite-local coordinates
    logic                hit1_q, hit1_d;
    logic [SPR_LOG2-1:0] dx_q, dx_d;
    logic [SPR_LOG2-1:0] dy_q, dy_d;
    dir_t                dir1_q, dir1_d;
    step_t               step1_q, step1_d;

    // Stage 3: hit delayed to match the ROM's read latency
    logic                hit2_q, hit2_d;

    // 11-bit differences; bit 10 is the borrow that flags beam left/above the sprite
    logic [10:0] dx_full, dy_full;
    logic        in_box;

    // Snapshot next-state: reload only on the frame tick, walk frame forced to 0 when idle
    always_comb begin
        snap_x_d    = snap_x_q;
        snap_y_d    = snap_y_q;
        snap_dir_d  = snap_dir_q;
        snap_step_d = snap_step_q;
        if (Frame_Tick) begin
            snap_x_d    = Player_X;
            snap_y_d    = Player_Y;
            snap_dir_d  = dir_t'(Player_Dir);
            snap_step_d = Player_Moving ? Obj_Step_Count : 2'd0;
        end
    end

    // Snapshot register; a pixel in the tick cycle still sees the old values
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            snap_x_q    <= '0;
            snap_y_q    <= '0;
            snap_dir_q  <= DIR_UP;
            snap_step_q <= '0;
        end else begin
            snap_x_q    <= snap_x_d;
            snap_y_q    <= snap_y_d;
            snap_dir_q  <= snap_dir_d;
            snap_step_q <= snap_step_d;
        end
    end

    // Box test against the current snapshot; no wrap-around, the borrow bit rejects
    always_comb begin
        dx_full = {1'b0, DrawX} - {1'b0, snap_x_q};
        dy_full = {1'b0, DrawY} - {1'b0, snap_y_q};
        in_box  = Blank_n & ~dx_full[10] & ~dy_full[10]
                & (dx_full[9:SPR_LOG2] == '0) & (dy_full[9:SPR_LOG2] == '0);
        hit1_d  = in_box;
        dx_d    = dx_full[SPR_LOG2-1:0];
        dy_d    = dy_full[SPR_LOG2-1:0];
        dir1_d  = snap_dir_q;
        step1_d = snap_step_q;
        hit2_d  = hit1_q;
    end

    // Pixel pipeline; address fields update even on misses, consumers gate on the hit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit1_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            dir1_q  <= DIR_UP;
            step1_q <= '0;
            hit2_q  <= 1'b0;
        end else begin
            hit1_q  <= hit1_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dir1_q  <= dir1_d;
            step1_q <= step1_d;
            hit2_q  <= hit2_d;
        end
    end

    // Frame index {dir, step} selects one of 16 sprite frames in the sheet
    assign Sprite_Addr = {dir1_q, step1_q, dy_q, dx_q};
    assign Sprite_Hit  = hit2_q;

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Bench for player_sprite_fetch: expectations from a frame-snapshot model are
// queued as pixels are driven and compared when the pipeline delivers them.
module tb_player_sprite_fetch;

    localparam int ADDR_W = 14;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Frame_Tick = 1'b0;
    logic [9:0]        Player_X = '0;
    logic [9:0]        Player_Y = '0;
    logic [1:0]        Player_Dir = '0;
    logic              Player_Moving = 1'b0;
    logic [1:0]        Obj_Step_Count = '0;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic              Blank_n = 1'b0;
    logic [ADDR_W-1:0] Sprite_Addr;
    logic              Sprite_Hit;

    player_sprite_fetch #(.SPR_LOG2(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_Tick(Frame_Tick),
        .Player_X(Player_X), .Player_Y(Player_Y), .Player_Dir(Player_Dir),
        .Player_Moving(Player_Moving), .Obj_Step_Count(Obj_Step_Count),
        .DrawX(DrawX), .DrawY(DrawY), .Blank_n(Blank_n),
        .Sprite_Addr(Sprite_Addr), .Sprite_Hit(Sprite_Hit)
    );

    always #5 Clk = ~Clk;

    typedef struct { int due; logic [ADDR_W-1:0] addr; } aexp_t;
    typedef struct { int due; logic hit; } hexp_t;
    typedef struct { int x; int y; bit b; bit t; } stim_t;

    aexp_t aq[$];
    hexp_t hq[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    // Model snapshot as the sprite logic should see it
    int sx = 0, sy = 0, sdir = 0, sstep = 0;

    // Drive one pixel and queue what it should produce; tick reloads the model afterwards
    task automatic drive_px(input int x, input int y, input bit blank, input bit tick);
        aexp_t a;
        hexp_t h;
        int dx, dy;
        DrawX = 10'(x);
        DrawY = 10'(y);
        Blank_n = blank;
        Frame_Tick = tick;
        dx = x - sx;
        dy = y - sy;
        a.due = cyc + 1;
        a.addr = {2'(sdir), 2'(sstep), 5'(dy & 31), 5'(dx & 31)};
        h.due = cyc + 2;
        h.hit = blank && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        aq.push_back(a);
        hq.push_back(h);
        if (tick) begin
            sx = int'(Player_X);
            sy = int'(Player_Y);
            sdir = int'(Player_Dir);
            sstep = Player_Moving ? int'(Obj_Step_Count) : 0;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (Sprite_Addr !== '0) begin
            n_err++;
            $display("FAIL reset_addr got=%h exp=0", Sprite_Addr);
        end
        n_cmp++;
        if (Sprite_Hit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hit got=%b exp=0", Sprite_Hit);
        end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // After reset the snapshot is at 0,0 facing up, frame 0
    task automatic test_reset_state();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        st.push_back('{3, 4, 1'b1, 1'b0});
        st.push_back('{40, 4, 1'b1, 1'b0});
        st.push_back('{31, 31, 1'b1, 1'b0});
        for (int i = 0; i < st.size() + 2; i++) begin
            @(negedge Clk); cyc++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL rst_state_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL rst_state_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            if (i < st.size()) drive_px(st[i].x, st[i].y, st[i].b, st[i].t);
            else begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
        end
    endtask

    // Snapshot X=100,Y=50,right,step 2; box edges in X and Y, blanking
    task automatic test_basic();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        Player_X = 10'd100; Player_Y = 10'd50; Player_Dir = 2'd3;
        Player_Moving = 1'b1; Obj_Step_Count = 2'd2;
        st.push_back('{0, 0, 1'b0, 1'b1});
        st.push_back('{105, 60, 1'b1, 1'b0});
        st.push_back('{99, 60, 1'b1, 1'b0});
        st.push_back('{131, 60, 1'b1, 1'b0});
        st.push_back('{132, 60, 1'b1, 1'b0});
        st.push_back('{120, 49, 1'b1, 1'b0});
        st.push_back('{120, 81, 1'b1, 1'b0});
        st.push_back('{120, 82, 1'b1, 1'b0});
        st.push_back('{120, 60, 1'b0, 1'b0});
        st.push_back('{100, 50, 1'b1, 1'b0});
        for (int i = 0; i < st.size() + 2; i++) begin
            @(negedge Clk); cyc++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL basic_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL basic_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            if (i < st.size()) drive_px(st[i].x, st[i].y, st[i].b, st[i].t);
            else begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
        end
    endtask

    // Sprite hanging off the right edge; left-of-sprite columns must not wrap
    task automatic test_clip();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        Player_X = 10'd620; Player_Y = 10'd50;
        st.push_back('{0, 0, 1'b0, 1'b1});
        for (int x = 610; x < 640; x++) st.push_back('{x, 60, 1'b1, 1'b0});
        for (int x = 0; x < 12; x++) st.push_back('{x, 60, 1'b1, 1'b0});
        for (int i = 0; i < st.size() + 2; i++) begin
            @(negedge Clk); cyc++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL clip_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL clip_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            if (i < st.size()) drive_px(st[i].x, st[i].y, st[i].b, st[i].t);
            else begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
        end
    endtask

    // Player inputs move mid-frame without a tick; then idle tick forces frame 0
    task automatic test_hold();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk); cyc++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL hold_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL hold_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            case (i)
                0: begin Player_X = 10'd200; Obj_Step_Count = 2'd1; drive_px(625, 60, 1'b1, 1'b0); end
                1: drive_px(630, 70, 1'b1, 1'b0);
                2: begin Player_Dir = 2'd1; drive_px(205, 60, 1'b1, 1'b0); end
                3: begin Player_Moving = 1'b0; Obj_Step_Count = 2'd3; drive_px(0, 0, 1'b0, 1'b1); end
                4: drive_px(205, 60, 1'b1, 1'b0);
                5: begin Obj_Step_Count = 2'd1; Player_Moving = 1'b1; drive_px(210, 61, 1'b1, 1'b0); end
                6: drive_px(625, 60, 1'b1, 1'b0);
                default: begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
            endcase
        end
    endtask

    // Tick in the same cycle as an in-box pixel: that pixel uses the old snapshot
    task automatic test_tick_coincident();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        Player_X = 10'd300; Player_Dir = 2'd2; Obj_Step_Count = 2'd1;
        st.push_back('{210, 60, 1'b1, 1'b1});
        st.push_back('{210, 60, 1'b1, 1'b0});
        st.push_back('{305, 60, 1'b1, 1'b0});
        for (int i = 0; i < st.size() + 2; i++) begin
            @(negedge Clk); cyc++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL tick_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL tick_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            if (i < st.size()) drive_px(st[i].x, st[i].y, st[i].b, st[i].t);
            else begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
        end
    endtask

    // Reset dropped between edges while hits stream; outputs clear at once, then refill
    task automatic test_midreset();
        stim_t st[$];
        aexp_t a;
        hexp_t h;
        @(negedge Clk); cyc++;
        drive_px(sx + 3, sy + 3, 1'b1, 1'b0);
        @(negedge Clk); cyc++;
        drive_px(sx + 4, sy + 3, 1'b1, 1'b0);
        @(negedge Clk); cyc++;
        n_cmp++;
        if (Sprite_Hit !== 1'b1) begin
            n_err++; $display("FAIL midrst_prehit got=%b exp=1", Sprite_Hit);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (Sprite_Addr !== '0) begin
            n_err++; $display("FAIL midrst_addr got=%h exp=0", Sprite_Addr);
        end
        n_cmp++;
        if (Sprite_Hit !== 1'b0) begin
            n_err++; $display("FAIL midrst_hit got=%b exp=0", Sprite_Hit);
        end
        aq.delete(); hq.delete();
        sx = 0; sy = 0; sdir = 0; sstep = 0;
        Blank_n = 1'b1; DrawX = 10'd5; DrawY = 10'd5;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if (Sprite_Hit !== 1'b0 || Sprite_Addr !== '0) begin
            n_err++; $display("FAIL midrst_held got=%b/%h exp=0/0", Sprite_Hit, Sprite_Addr);
        end
        Reset_n = 1'b1;
        st.push_back('{5, 5, 1'b1, 1'b0});
        st.push_back('{6, 7, 1'b1, 1'b0});
        st.push_back('{33, 7, 1'b1, 1'b0});
        for (int i = 0; i < st.size() + 2; i++) begin
            if (i > 0) begin @(negedge Clk); cyc++; end
            if (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front(); n_cmp++;
                if (Sprite_Addr !== a.addr) begin
                    n_err++; $display("FAIL refill_addr cyc=%0d got=%h exp=%h", cyc, Sprite_Addr, a.addr);
                end
            end
            if (hq.size() > 0 && hq[0].due == cyc) begin
                h = hq.pop_front(); n_cmp++;
                if (Sprite_Hit !== h.hit) begin
                    n_err++; $display("FAIL refill_hit cyc=%0d got=%b exp=%b", cyc, Sprite_Hit, h.hit);
                end
            end
            if (i < st.size()) drive_px(st[i].x, st[i].y, st[i].b, st[i].t);
            else begin Blank_n = 1'b0; Frame_Tick = 1'b0; end
        end
    endtask

    initial begin
        test_reset();
        test_reset_state();
        test_basic();
        test_clip();
        test_hold();
        test_tick_coincident();
        test_midreset();
        if (aq.size() != 0 || hq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending_addr=%0d pending_hit=%0d exp=0/0", aq.size(), hq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
